// File: rtl/lfsr_sched_if.sv
// Requester- and LFSR-side signals of lfsr_sched.
// master = the scheduler; slave = the requesters together with the external LFSR.
interface lfsr_sched_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       req;
   logic [1:0]       gnt;
   logic [WIDTH-1:0] rnd;
   logic             rnd_valid;
   logic             seed_load;
   logic [WIDTH-1:0] seed_val;
   logic             busy;
   logic             lfsr_load;
   logic [WIDTH-1:0] lfsr_seed;
   logic             lfsr_en;
   logic [WIDTH-1:0] lfsr_q;

   modport master (
      input  req, seed_load, seed_val, lfsr_q,
      output gnt, rnd, rnd_valid, busy, lfsr_load, lfsr_seed, lfsr_en
   );

   modport slave (
      output req, seed_load, seed_val, lfsr_q,
      input  gnt, rnd, rnd_valid, busy, lfsr_load, lfsr_seed, lfsr_en
   );
endinterface

// File: rtl/lfsr_sched.sv
// Seeds, steps and shares one external LFSR between two round-robin requesters.
// Request sampled at E0 -> STEPS enable cycles -> DELIVER -> gnt/rnd_valid pulse in cycle STEPS+2.
module lfsr_sched #(
   parameter int               WIDTH = 8,
   parameter int               STEPS = 8,
   parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic         clk,
   input  logic         rst,
   lfsr_sched_if.master bus
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_LOAD,
      S_STEP,
      S_DELIVER
   } state_t;

   localparam int            CW       = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             win_q, win_d;
   logic             rr_q, rr_d;
   logic             pend_q, pend_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [WIDTH-1:0] rnd_q, rnd_d;
   logic             vld_q, vld_d;
   logic             load_q, load_d;
   logic [WIDTH-1:0] lseed_q, lseed_d;
   logic             en_q, en_d;

   logic [1:0]       avail;
   logic             pick;

   // Masking with gnt_q keeps a requester from being re-served in its own grant cycle.
   assign avail = bus.req & ~gnt_q;
   assign pick  = (avail == 2'b11) ? ~rr_q : avail[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         win_q   <= 1'b0;
         rr_q    <= 1'b1;
         pend_q  <= 1'b0;
         seed_q  <= '0;
         gnt_q   <= '0;
         rnd_q   <= '0;
         vld_q   <= 1'b0;
         load_q  <= 1'b0;
         lseed_q <= SEED;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
         rr_q    <= rr_d;
         pend_q  <= pend_d;
         seed_q  <= seed_d;
         gnt_q   <= gnt_d;
         rnd_q   <= rnd_d;
         vld_q   <= vld_d;
         load_q  <= load_d;
         lseed_q <= lseed_d;
         en_q    <= en_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      pend_d  = pend_q;
      seed_d  = bus.seed_load ? bus.seed_val : seed_q;
      case (state_q)
         S_INIT: state_d = S_IDLE;
         S_IDLE: begin
            if (pend_q || bus.seed_load) begin
               state_d = S_LOAD;
            end else if (|avail) begin
               state_d = S_STEP;
               win_d   = pick;
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
         end
         S_STEP: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_DELIVER;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DELIVER: state_d = S_IDLE;
         default:   state_d = S_INIT;
      endcase
      // A pulse arriving outside IDLE (even during LOAD) is deferred to the next IDLE.
      if (bus.seed_load && state_q != S_IDLE) begin
         pend_d = 1'b1;
      end
   end

   always_comb begin
      gnt_d   = '0;
      vld_d   = 1'b0;
      rnd_d   = rnd_q;
      rr_d    = rr_q;
      lseed_d = lseed_q;
      en_d    = (state_d == S_STEP);
      load_d  = (state_q == S_INIT) || (state_d == S_LOAD);
      if (state_q == S_INIT) begin
         lseed_d = SEED;
      end else if (state_d == S_LOAD) begin
         lseed_d = (seed_d == '0) ? SEED : seed_d;
      end
      if (state_q == S_DELIVER) begin
         rnd_d = bus.lfsr_q;
         vld_d = 1'b1;
         gnt_d = win_q ? 2'b10 : 2'b01;
         rr_d  = win_q;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.rnd       = rnd_q;
   assign bus.rnd_valid = vld_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.lfsr_load = load_q;
   assign bus.lfsr_seed = lseed_q;
   assign bus.lfsr_en   = en_q;

endmodule

// File: tb/tb_lfsr_sched.sv
// Directed bench for lfsr_sched with an external LFSR model and a delivery scoreboard.
module tb_lfsr_sched;

   localparam int STEPS = 8;

   typedef struct packed {
      logic [1:0] gnt;
      logic [7:0] rnd;
   } exp_t;

   logic clk;
   logic rst;
   lfsr_sched_if #(.WIDTH(8)) bus ();

   lfsr_sched #(.WIDTH(8), .STEPS(STEPS), .SEED(8'h01)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   exp_t sb[$];
   int   deliv_cnt = 0;
   int   load_cnt = 0;
   int   last_load_cyc = 0;
   int   start_cyc = 0;
   int   busy_cnt = 0;
   int   en_cnt = 0;
   logic prev_busy = 1'b1;
   logic [7:0] lq = 8'h00;
   logic [7:0] sw;
   int   load_snap;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

   function automatic logic [7:0] adv(input logic [7:0] q);
      logic [7:0] r = q;
      for (int i = 0; i < STEPS; i++) r = lfsr_next(r);
      return r;
   endfunction

   // External LFSR: load has priority over enable.
   always @(posedge clk) begin
      if (bus.lfsr_load) lq <= bus.lfsr_seed;
      else if (bus.lfsr_en) lq <= lfsr_next(lq);
   end
   assign bus.lfsr_q = lq;

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check(32'(bus.gnt), 0, {tag, "_gnt"});
      check(32'(bus.rnd), 0, {tag, "_rnd"});
      check(32'(bus.rnd_valid), 0, {tag, "_rnd_valid"});
      check(32'(bus.lfsr_en), 0, {tag, "_lfsr_en"});
      check(32'(bus.lfsr_load), 0, {tag, "_lfsr_load"});
      check(32'(bus.lfsr_seed), 32'h01, {tag, "_lfsr_seed"});
      check(32'(bus.busy), 1, {tag, "_busy"});
   endtask

   task automatic wait_deliv(input int target, input string tag);
      int n = 0;
      while (deliv_cnt < target && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      check(32'(deliv_cnt >= target), 1, {"timeout_", tag});
   endtask

   task automatic wait_en(input string tag);
      int n = 0;
      while (!bus.lfsr_en && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      check(32'(bus.lfsr_en), 1, {"timeout_", tag});
   endtask

   task automatic pulse_seed(input logic [7:0] v);
      bus.seed_val  = v;
      bus.seed_load = 1'b1;
      @(negedge clk); #1;
      bus.seed_load = 1'b0;
   endtask

   // Monitor: scoreboard pop, per-delivery timing, and per-cycle invariants.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         en_cnt    = 0;
         busy_cnt  = 0;
         prev_busy = 1'b1;
      end else begin
         if (bus.busy && !prev_busy) begin
            start_cyc = cyc;
            busy_cnt  = 0;
         end
         if (bus.busy) busy_cnt++;
         prev_busy = bus.busy;
         if (bus.lfsr_en) en_cnt++;
         if (bus.lfsr_load) begin
            load_cnt++;
            last_load_cyc = cyc;
         end
         check(32'(bus.lfsr_load & bus.lfsr_en), 0, "load_en_exclusive");
         if (bus.rnd_valid) begin
            deliv_cnt++;
            check(32'(sb.size() > 0), 1, "unexpected_delivery");
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check(32'(bus.gnt), 32'(e.gnt), "deliv_gnt");
               check(32'(bus.rnd), 32'(e.rnd), "deliv_rnd");
            end
            check(32'(en_cnt), STEPS, "en_cycles");
            check(32'(cyc - start_cyc), STEPS + 1, "latency");
            check(32'(busy_cnt), STEPS + 1, "busy_cycles");
            en_cnt = 0;
         end else begin
            check(32'(bus.gnt), 0, "gnt_without_valid");
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.req = 2'b00;
      bus.seed_load = 1'b0;
      bus.seed_val = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      check_reset("reset");

      // 1: single requester 0 from the power-up seed
      rst = 1'b0;
      bus.req = 2'b01;
      sw = adv(8'h01);
      sb.push_back('{gnt: 2'b01, rnd: sw});
      wait_deliv(1, "t1");
      bus.req = 2'b00;
      check(32'(bus.rnd), 32'h1C, "t1_rnd_1c");
      repeat (15) @(negedge clk);
      #1;
      check(32'(deliv_cnt), 1, "t1_no_regrant");

      // 2: single requester 1
      bus.req = 2'b10;
      sw = adv(sw);
      sb.push_back('{gnt: 2'b10, rnd: sw});
      wait_deliv(2, "t2");
      bus.req = 2'b00;
      check(32'(bus.rnd), 32'h4B, "t2_rnd_4b");
      repeat (3) @(negedge clk);
      #1;

      // 3: both requesting continuously -> strict alternation
      bus.req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         sw = adv(sw);
         sb.push_back('{gnt: (i % 2 == 0) ? 2'b01 : 2'b10, rnd: sw});
      end
      wait_deliv(6, "t3");
      bus.req = 2'b00;
      repeat (3) @(negedge clk);
      #1;

      // 4: reseed in IDLE, zero seed substituted, then a real seed
      pulse_seed(8'h00);
      check(32'(bus.lfsr_load), 1, "t4_zero_load");
      check(32'(bus.lfsr_seed), 32'h01, "t4_zero_guard");
      @(negedge clk); #1;
      check(32'(bus.lfsr_load), 0, "t4_load_one_cycle");
      pulse_seed(8'hA5);
      check(32'(bus.lfsr_load), 1, "t4_a5_load");
      check(32'(bus.lfsr_seed), 32'hA5, "t4_a5_seed");
      @(negedge clk); #1;
      bus.req = 2'b01;
      sw = adv(8'hA5);
      sb.push_back('{gnt: 2'b01, rnd: sw});
      wait_deliv(7, "t4");
      bus.req = 2'b00;
      repeat (3) @(negedge clk);
      #1;

      // 5: seed_load during STEP is deferred until after the in-flight grant
      bus.req = 2'b10;
      sb.push_back('{gnt: 2'b10, rnd: adv(sw)});
      sb.push_back('{gnt: 2'b01, rnd: adv(8'h3C)});
      wait_en("t5_en");
      repeat (2) @(negedge clk);
      #1;
      load_snap = load_cnt;
      pulse_seed(8'h77);
      pulse_seed(8'h3C);
      bus.req = 2'b11;
      wait_deliv(8, "t5_first");
      bus.req = 2'b01;
      check(32'(load_cnt), 32'(load_snap), "t5_no_load_in_flight");
      wait_deliv(9, "t5_second");
      bus.req = 2'b00;
      check(32'(load_cnt), 32'(load_snap + 1), "t5_one_load");
      check(32'(last_load_cyc < start_cyc), 1, "t5_load_before_step");
      repeat (3) @(negedge clk);
      #1;

      // 6: reset mid-STEP aborts the request; INIT reloads the power-up seed
      bus.req = 2'b10;
      sb.push_back('{gnt: 2'b10, rnd: 8'h00});
      wait_en("t6_en");
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_reset("t6_midreset");
      sb.delete();
      repeat (3) @(negedge clk);
      #1;
      check(32'(deliv_cnt), 9, "t6_no_aborted_grant");
      rst = 1'b0;
      sb.push_back('{gnt: 2'b10, rnd: adv(8'h01)});
      wait_deliv(10, "t6");
      bus.req = 2'b00;
      check(32'(bus.rnd), 32'h1C, "t6_rnd_1c");
      repeat (15) @(negedge clk);
      #1;
      check(32'(deliv_cnt), 10, "final_deliveries");
      check(32'(sb.size()), 0, "scoreboard_empty");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
